// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the serial-in/parallel-out deserialiser.
package sipo_pkg;
    localparam bit SIPO_LSB_FIRST = 1'b0;
    localparam bit SIPO_MSB_FIRST = 1'b1;
    localparam int SIPO_DEF_WIDTH = 8;

    function automatic int sipo_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input, parallel output handshake and status bundle.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH,
    parameter int CNT_W = sipo_cnt_w(WIDTH)
) ();
    logic             sin;
    logic             sin_en;
    logic             clear;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    modport master (
        output sin, sin_en, clear, out_ready,
        input  q, par_out, out_valid, bit_cnt, overrun
    );
    modport slave (
        input  sin, sin_en, clear, out_ready,
        output q, par_out, out_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_shift_chain.sv
// sipo_shift_chain: enable-qualified shift chain of per-bit flops with sync clear.
module sipo_shift_chain
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = SIPO_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] d_o
);
    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] shift;

    // sin only reaches d_o when enabled, so an undriven line cannot leak in
    always_comb begin
        shift = MSB_FIRST ? {chain_q[WIDTH-2:0], sin_i} : {sin_i, chain_q[WIDTH-1:1]};
        d_o   = clear_i ? '0 : en_i ? shift : chain_q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) chain_q[i] <= 1'b0;
            else if (en_i || clear_i) chain_q[i] <= d_o[i];
    end

    assign q_o = chain_q;
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: frames WIDTH serial bits into a one-entry valid/ready holding register.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = SIPO_MSB_FIRST,
    parameter int CNT_W     = sipo_cnt_w(WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    sipo_deser_if.slave bus
);
    logic [WIDTH-1:0] chain_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             accept, done, free;

    sipo_shift_chain #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_chain (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (bus.sin_en),
        .clear_i (bus.clear),
        .sin_i   (bus.sin),
        .q_o     (bus.q),
        .d_o     (chain_d)
    );

    // a consume in the same cycle frees the slot, so a new word loads with no bubble
    always_comb begin
        accept  = bus.sin_en && !bus.clear;
        done    = accept && cnt_q == CNT_W'(WIDTH - 1);
        free    = !valid_q || bus.out_ready;
        cnt_d   = (bus.clear || done) ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
        par_d   = (done && free) ? chain_d : par_q;
        valid_d = (done && free) ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
        ovr_d   = bus.clear ? 1'b0 : (done && !free) ? 1'b1 : ovr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end

    assign bus.par_out   = par_q;
    assign bus.out_valid = valid_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: MSB-first and LSB-first instances checked against a bit-history model.
module tb_sipo_deser;
    import sipo_pkg::*;
    localparam int W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sin = 1'b0, sin_en = 1'b0, clr = 1'b0, rdy = 1'b0;
    int   tests = 0, fails = 0;
    bit   run_chk = 1'b0;

    sipo_deser_if #(.WIDTH(W)) bm ();
    sipo_deser_if #(.WIDTH(W)) bl ();

    assign bm.sin = sin;  assign bm.sin_en = sin_en;  assign bm.clear = clr;  assign bm.out_ready = rdy;
    assign bl.sin = sin;  assign bl.sin_en = sin_en;  assign bl.clear = clr;  assign bl.out_ready = rdy;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(SIPO_MSB_FIRST)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bm));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(SIPO_LSB_FIRST)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));

    always #5 clk = ~clk;

    // model: accepted bits since the last clear, word position, holding slot
    bit         win[$];
    int         nb;
    logic [7:0] m_par_m, m_par_l;
    bit         m_vld, m_ovr;

    function automatic logic [7:0] live(input bit msb);
        logic [7:0] v = '0;
        for (int k = 0; k < win.size(); k++)
            if (msb) v[k] = win[win.size() - 1 - k];
            else     v[W - 1 - k] = win[win.size() - 1 - k];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit done;
        if (!rst_n) begin
            win.delete(); nb = 0; m_par_m = '0; m_par_l = '0; m_vld = 0; m_ovr = 0;
        end else begin
            done = 0;
            if (clr) begin
                win.delete(); nb = 0; m_ovr = 0;
            end else if (sin_en) begin
                win.push_back(sin);
                if (win.size() > W) void'(win.pop_front());
                nb++;
                if (nb == W) begin nb = 0; done = 1; end
            end
            if (done && (!m_vld || rdy)) begin
                m_par_m = live(1); m_par_l = live(0); m_vld = 1;
            end else if (done) m_ovr = 1;
            else if (m_vld && rdy) m_vld = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run_chk) begin
        chk("m.q",       32'(bm.q),         32'(live(1)));
        chk("m.par_out", 32'(bm.par_out),   32'(m_par_m));
        chk("m.valid",   32'(bm.out_valid), 32'(m_vld));
        chk("m.bit_cnt", 32'(bm.bit_cnt),   32'(nb));
        chk("m.overrun", 32'(bm.overrun),   32'(m_ovr));
        chk("l.q",       32'(bl.q),         32'(live(0)));
        chk("l.par_out", 32'(bl.par_out),   32'(m_par_l));
        chk("l.valid",   32'(bl.out_valid), 32'(m_vld));
        chk("l.bit_cnt", 32'(bl.bit_cnt),   32'(nb));
        chk("l.overrun", 32'(bl.overrun),   32'(m_ovr));
    end

    task automatic step(input logic b, input logic en, input logic r, input logic c);
        sin = b; sin_en = en; rdy = r; clr = c;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, r, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        logic [3:0] cnt_s;
        logic [7:0] q_s;
        repeat (2) @(negedge clk);
        chk("reset q",     32'(bm.q),         32'h0);
        chk("reset par",   32'(bm.par_out),   32'h0);
        chk("reset valid", 32'(bm.out_valid), 32'h0);
        chk("reset cnt",   32'(bm.bit_cnt),   32'h0);
        chk("reset ovr",   32'(bm.overrun),   32'h0);
        rst_n = 1'b1;
        run_chk = 1'b1;

        // basic framing, both bit orders
        w = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            step(w[i], 1'b1, 1'b1, 1'b0);
            if (i == 4) chk("lsb q after 4", 32'(bl.q), 32'hD0);
            if (i == 1) chk("valid before 8th", 32'(bm.out_valid), 32'h0);
        end
        chk("msb word",    32'(bm.par_out),   32'hB2);
        chk("lsb word",    32'(bl.par_out),   32'h4D);
        chk("valid after", 32'(bm.out_valid), 32'h1);
        chk("cnt wrapped", 32'(bm.bit_cnt),   32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("consumed", 32'(bm.out_valid), 32'h0);

        // overrun
        send_word(8'hB2, 1'b0);
        send_word(8'h0F, 1'b0);
        chk("ovr par",   32'(bm.par_out),   32'hB2);
        chk("ovr valid", 32'(bm.out_valid), 32'h1);
        chk("ovr set",   32'(bm.overrun),   32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr drain valid", 32'(bm.out_valid), 32'h0);
        chk("ovr sticky",      32'(bm.overrun),   32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ovr cleared", 32'(bm.overrun), 32'h0);
        chk("clear q",     32'(bm.q),       32'h0);

        // back-to-back with consume on the completing cycle
        send_word(8'h5A, 1'b0);
        w = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            step(w[i], 1'b1, i == 0, 1'b0);
            chk("b2b valid held", 32'(bm.out_valid), 32'h1);
            if (i == 1) chk("b2b old word", 32'(bm.par_out), 32'h5A);
        end
        chk("b2b new word", 32'(bm.par_out), 32'hC3);
        chk("b2b no ovr",   32'(bm.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // gapped enable
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            step(w[i], 1'b1, 1'b0, 1'b0);
            cnt_s = bm.bit_cnt; q_s = bm.q;
            step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
            chk("idle cnt hold", 32'(bm.bit_cnt), 32'(cnt_s));
            chk("idle q hold",   32'(bm.q),       32'(q_s));
        end
        chk("gapped msb", 32'(bm.par_out), 32'hA5);
        chk("gapped lsb", 32'(bl.par_out), 32'hA5);

        // asynchronous reset mid-word with a word pending
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async q",     32'(bm.q),         32'h0);
        chk("async cnt",   32'(bm.bit_cnt),   32'h0);
        chk("async valid", 32'(bm.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h3C, 1'b1);
        chk("post-reset msb", 32'(bm.par_out),   32'h3C);
        chk("post-reset lsb", 32'(bl.par_out),   32'h3C);
        chk("post-reset vld", 32'(bm.out_valid), 32'h1);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(1)), $urandom_range(3) != 0, 1'($urandom_range(1)),
                 $urandom_range(39) == 0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(1)), 1'b1, $urandom_range(7) == 0, 1'b0);

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
